// File: rtl/jtpang_objdma_if.sv
// CPU-side bus of the Pang object DMA: bus request/acknowledge pair plus the
// VRAM DMA read port (address out, registered data back one clk later).
interface jtpang_objdma_if #(parameter int OBJW = 9);
    logic            busrq_n;
    logic            busak_n;
    logic [OBJW-1:0] dma_addr;
    logic [7:0]      vram_dout;

    modport master (output busrq_n, output dma_addr, input busak_n, input vram_dout);
    modport slave  (input busrq_n, input dma_addr, output busak_n, output vram_dout);
endinterface

// File: rtl/jtpang_objdma.sv
// Pang object-table DMA: copies the 512-byte object table from VRAM into a private
// object buffer. Define JTPANG_OBJDMA_DBUF_EN for a double-buffered object buffer.
module jtpang_objdma #(
    parameter int OBJW = 9
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_cen,
    input  logic            i_dma_trig,
    input  logic            i_vb,
    jtpang_objdma_if.master bus,
    input  logic [OBJW-1:0] i_obj_addr,
    output logic [7:0]      o_obj_dout,
    output logic            o_dma_busy,
    output logic            o_fresh,
    output logic [2:0]      o_dbg_state
);
    localparam int              DEPTH = 1 << OBJW;
    localparam logic [OBJW-1:0] LAST  = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_ADDR = 3'd2,
        ST_DATA = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    state_t          r_state, w_state_nx;
    logic            r_pend, r_busrq_n, r_busy, r_fresh;
    logic [OBJW-1:0] r_addr;
    logic            w_wr, w_swap;
    logic [7:0]      r_obj_dout;

    // Handshake: busrq_n is held low from REQ until DONE; the bus is ours only while
    // busak_n is low, and any cen step with busak_n high stalls REQ/ADDR/DATA in place.
    always_comb begin
        w_state_nx = r_state;
        w_wr       = 1'b0;
        case (r_state)
            ST_IDLE: if (r_pend) w_state_nx = ST_REQ;
            ST_REQ:  if (!bus.busak_n) w_state_nx = ST_ADDR;
            ST_ADDR: if (!bus.busak_n) w_state_nx = ST_DATA;
            ST_DATA: begin
                if (!bus.busak_n) begin
                    w_wr       = i_cen;
                    w_state_nx = (r_addr == LAST) ? ST_DONE : ST_ADDR;
                end
            end
            ST_DONE: w_state_nx = ST_IDLE;
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_busrq_n <= 1'b1;
            r_busy    <= 1'b0;
            r_addr    <= '0;
            r_fresh   <= 1'b0;
        end else if (i_cen) begin
            r_state <= w_state_nx;
            case (r_state)
                ST_IDLE: if (r_pend) r_busy <= 1'b1;
                ST_REQ:  r_busrq_n <= 1'b0;
                ST_DATA: if (w_wr && r_addr != LAST) r_addr <= r_addr + 1'b1;
                ST_DONE: begin
                    r_busrq_n <= 1'b1;
                    r_busy    <= 1'b0;
                    r_addr    <= '0;
                    r_fresh   <= 1'b1;
                end
                default: ;
            endcase
            if (w_swap) r_fresh <= 1'b0;
        end
    end

    // A trigger on the same clk as leaving IDLE (or during DONE) stays latched.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend <= 1'b0;
        end else if (i_dma_trig) begin
            r_pend <= 1'b1;
        end else if (i_cen && r_state == ST_IDLE) begin
            r_pend <= 1'b0;
        end
    end

`ifdef JTPANG_OBJDMA_DBUF_EN
    logic             r_vb_l, r_front;
    logic [7:0]       r_mem [0:2*DEPTH-1];
    logic [OBJW:0]    w_waddr, w_raddr;

    // Never swap while a transfer owns the back bank; fresh keeps the swap pending.
    assign w_swap  = i_cen & i_vb & ~r_vb_l & r_fresh & ~r_busy;
    assign w_waddr = {~r_front, r_addr};
    assign w_raddr = {r_front, i_obj_addr};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vb_l  <= 1'b0;
            r_front <= 1'b0;
        end else if (i_cen) begin
            r_vb_l <= i_vb;
            if (w_swap) r_front <= ~r_front;
        end
    end
`else
    logic             w_unused_vb;
    logic [7:0]       r_mem [0:DEPTH-1];
    logic [OBJW-1:0]  w_waddr, w_raddr;

    assign w_unused_vb = i_vb;
    assign w_swap      = 1'b0;
    assign w_waddr     = r_addr;
    assign w_raddr     = i_obj_addr;
`endif

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_waddr] <= bus.vram_dout;
        r_obj_dout <= r_mem[w_raddr];
    end

    assign bus.busrq_n  = r_busrq_n;
    assign bus.dma_addr = r_addr;
    assign o_obj_dout   = r_obj_dout;
    assign o_dma_busy   = r_busy;
    assign o_fresh      = r_fresh;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_jtpang_objdma.sv
// Bench for jtpang_objdma: random cen and VRAM data, object buffer compared against
// an array model of the banks updated per completed (or cut-short) transfer.
`timescale 1ns/1ps
module tb_jtpang_objdma;
    localparam int OBJW = 9;
    localparam int N    = 512;
`ifdef JTPANG_OBJDMA_DBUF_EN
    localparam int DBUF = 1;
`else
    localparam int DBUF = 0;
`endif

    logic            clk      = 1'b0;
    logic            rst      = 1'b1;
    logic            cen      = 1'b0;
    logic            dma_trig = 1'b0;
    logic            vb       = 1'b0;
    logic [OBJW-1:0] obj_addr = '0;
    logic [7:0]      obj_dout;
    logic            dma_busy, fresh;
    logic [2:0]      dbg_state;

    jtpang_objdma_if #(.OBJW(OBJW)) bus();

    jtpang_objdma #(.OBJW(OBJW)) dut (
        .clk        (clk),
        .rst        (rst),
        .i_cen      (cen),
        .i_dma_trig (dma_trig),
        .i_vb       (vb),
        .bus        (bus),
        .i_obj_addr (obj_addr),
        .o_obj_dout (obj_dout),
        .o_dma_busy (dma_busy),
        .o_fresh    (fresh),
        .o_dbg_state(dbg_state)
    );

    logic [7:0] vram    [0:N-1];
    logic [7:0] exp_mem [0:2*N-1];
    int exp_front = 0;
    int exp_fresh = 0;
    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;
    always @(negedge clk) cen <= ($urandom_range(0, 3) != 0);
    always @(posedge clk) bus.vram_dout <= vram[bus.dma_addr];

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cen_step();
        do @(posedge clk); while (!cen);
        #1;
    endtask

    task automatic cen_steps(input int n);
        for (int i = 0; i < n; i++) cen_step();
    endtask

    task automatic pulse_trig();
        @(negedge clk); dma_trig = 1'b1;
        @(negedge clk); dma_trig = 1'b0;
    endtask

    task automatic read_obj(input int a, output logic [7:0] d);
        @(negedge clk); obj_addr = a[OBJW-1:0];
        @(posedge clk); #1;
        d = obj_dout;
    endtask

    function automatic int bank_w();
        return DBUF * (1 - exp_front);
    endfunction

    function automatic int bank_r();
        return DBUF * exp_front;
    endfunction

    task automatic fill(input int random_data);
        for (int i = 0; i < N; i++)
            vram[i] = (random_data != 0) ? 8'($urandom_range(0, 255)) : (8'(i) ^ 8'h5A);
    endtask

    task automatic model_copy(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) exp_mem[bank_w() * N + i] = vram[i];
    endtask

    task automatic check_buf(input string tag);
        logic [7:0] d;
        for (int i = 0; i < N; i++) begin
            read_obj(i, d);
            chk($sformatf("%s[%0d]", tag, i), {8'h0, d}, {8'h0, exp_mem[bank_r() * N + i]});
        end
    endtask

    // Trigger, wait for the request, then acknowledge; returns right after the ack step.
    task automatic start_xfer(input string tag);
        int k;
        pulse_trig();
        k = 0;
        while (bus.busrq_n !== 1'b0 && k < 4) begin cen_step(); k++; end
        chk({tag, "_req"}, {15'h0, bus.busrq_n}, 16'h0);
        cen_steps($urandom_range(0, 3));
        bus.busak_n = 1'b0;
        cen_step();
    endtask

    task automatic finish_xfer(input string tag, input int budget);
        int k;
        k = 0;
        while (bus.busrq_n !== 1'b1 && k < budget) begin cen_step(); k++; end
        chk({tag, "_rel"}, {15'h0, bus.busrq_n}, 16'h1);
        bus.busak_n = 1'b1;
        model_copy(0, N - 1);
        exp_fresh = 1;
    endtask

    task automatic vb_pulse(input int busy);
        vb = 1'b1;
        cen_steps(2);
        vb = 1'b0;
        cen_step();
        if (DBUF != 0 && busy == 0 && exp_fresh != 0) begin
            exp_front = 1 - exp_front;
            exp_fresh = 0;
        end
    endtask

    task automatic show();
`ifdef JTPANG_OBJDMA_DBUF_EN
        vb_pulse(0);
`endif
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        bus.busak_n = 1'b1;
        for (int i = 0; i < 2 * N; i++) exp_mem[i] = 8'h00;
        fill(0);

        repeat (4) @(posedge clk);
        #1;
        chk("rst_busrq_n", {15'h0, bus.busrq_n}, 16'h1);
        chk("rst_busy", {15'h0, dma_busy}, 16'h0);
        chk("rst_addr", {7'h0, bus.dma_addr}, 16'h0);
        chk("rst_fresh", {15'h0, fresh}, 16'h0);
        @(negedge clk); rst = 1'b0;

        // Pattern copy with exact step timing.
        fill(0);
        pulse_trig();
        cen_step();
        chk("t1_rq_step1", {15'h0, bus.busrq_n}, 16'h1);
        chk("t1_busy", {15'h0, dma_busy}, 16'h1);
        cen_step();
        chk("t1_rq_step2", {15'h0, bus.busrq_n}, 16'h0);
        cen_steps(3);
        chk("t1_wait_addr", {7'h0, bus.dma_addr}, 16'h0);
        bus.busak_n = 1'b0;
        cen_step();
        cen_steps(200);
        chk("t1_addr100", {7'h0, bus.dma_addr}, 16'd100);
        cen_steps(824);
        chk("t1_rq_1024", {15'h0, bus.busrq_n}, 16'h0);
        chk("t1_addr511", {7'h0, bus.dma_addr}, 16'd511);
        cen_step();
        exp_fresh = 1;
        chk("t1_rq_1025", {15'h0, bus.busrq_n}, 16'h1);
        chk("t1_busy_done", {15'h0, dma_busy}, 16'h0);
        chk("t1_addr_done", {7'h0, bus.dma_addr}, 16'h0);
        chk("t1_fresh", {15'h0, fresh}, 16'h1);
        bus.busak_n = 1'b1;
        model_copy(0, N - 1);
        show();
        check_buf("t1_buf");

        // Random data copy.
        fill(1);
        start_xfer("t2");
        finish_xfer("t2", 1100);
        show();
        check_buf("t2_buf");

        // Bus taken back for 10 steps at address 100.
        fill(0);
        start_xfer("t3");
        cen_steps(200);
        chk("t3_addr100", {7'h0, bus.dma_addr}, 16'd100);
        bus.busak_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cen_step();
            chk($sformatf("t3_gap_addr%0d", i), {7'h0, bus.dma_addr}, 16'd100);
        end
`ifndef JTPANG_OBJDMA_DBUF_EN
        read_obj(100, d);
        chk("t3_gap_b100", {8'h0, d}, {8'h0, exp_mem[100]});
        read_obj(99, d);
        chk("t3_gap_b99", {8'h0, d}, {8'h0, vram[99]});
`endif
        bus.busak_n = 1'b0;
        finish_xfer("t3", 1100);
        show();
        check_buf("t3_buf");

        // Trigger mid-transfer queues a second full transfer.
        fill(1);
        start_xfer("t4");
        cen_steps(600);
        chk("t4_addr300", {7'h0, bus.dma_addr}, 16'd300);
        pulse_trig();
        finish_xfer("t4a", 600);
        fill(1);
        cen_step();
        chk("t4_rq_again1", {15'h0, bus.busrq_n}, 16'h1);
        chk("t4_busy_again", {15'h0, dma_busy}, 16'h1);
        cen_step();
        chk("t4_rq_again2", {15'h0, bus.busrq_n}, 16'h0);
        cen_steps($urandom_range(0, 3));
        bus.busak_n = 1'b0;
        cen_step();
        finish_xfer("t4b", 1100);
        cen_steps(4);
        chk("t4_no_third", {15'h0, bus.busrq_n}, 16'h1);
        chk("t4_idle_busy", {15'h0, dma_busy}, 16'h0);
        show();
        check_buf("t4_buf");

        // Reset at address 200 leaves a partially updated buffer.
        fill(1);
        start_xfer("t5");
        cen_steps(400);
        chk("t5_addr200", {7'h0, bus.dma_addr}, 16'd200);
        rst = 1'b1;
        #1;
        chk("t5_rst_busrq_n", {15'h0, bus.busrq_n}, 16'h1);
        chk("t5_rst_busy", {15'h0, dma_busy}, 16'h0);
        chk("t5_rst_addr", {7'h0, bus.dma_addr}, 16'h0);
        model_copy(0, 199);
        exp_front = 0;
        exp_fresh = 0;
        @(negedge clk); rst = 1'b0;
        bus.busak_n = 1'b1;
        chk("t5_fresh", {15'h0, fresh}, 16'h0);
        check_buf("t5_buf");

`ifdef JTPANG_OBJDMA_DBUF_EN
        // Front bank holds A until a vb rise after B completes.
        fill(1);
        start_xfer("da");
        finish_xfer("da", 1100);
        vb_pulse(0);
        fill(1);
        start_xfer("db");
        finish_xfer("db", 1100);
        chk("db_fresh", {15'h0, fresh}, 16'h1);
        check_buf("dbuf_hold");
        vb_pulse(0);
        chk("db_fresh_clr", {15'h0, fresh}, 16'h0);
        check_buf("dbuf_swap");

        // A vb rise during a transfer does not swap; the next one does.
        fill(1);
        start_xfer("dd");
        finish_xfer("dd", 1100);
        fill(1);
        start_xfer("dc");
        cen_steps(100);
        vb_pulse(1);
        check_buf("dbuf_defer");
        finish_xfer("dc", 1100);
        vb_pulse(0);
        check_buf("dbuf_after");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/jtpang_objdma.md
# jtpang_objdma

Object-table DMA engine for the Pang video path. On a CPU trigger it requests the CPU bus and copies the 512-byte object table from the upper half of the shared character/object VRAM into a private object buffer. It drives the VRAM DMA address and `busak_n`-qualified mux of the tile-map stage. The object line renderer downstream reads its attributes only from this buffer, never from CPU-visible VRAM.

## Interface
Parameters:
- `OBJW`, 9: object-table address width (512 bytes).

Ports:
- `rst` in 1: asynchronous, active-high reset.
- `clk` in 1: system clock.
- `cen` in 1: DMA step enable (CPU clock rate); all state changes only on `clk` with `cen`=1, except reset.
- `dma_trig` in 1: one-`clk` pulse from the CPU write decode of the DMA port.
- `vb` in 1: vertical blank; used only for the buffer swap.
- `busrq_n` out 1: bus request to the CPU, active low.
- `busak_n` in 1: bus acknowledge from the CPU, active low.
- `dma_addr` out 9: VRAM DMA address; VRAM maps it to `{1'b1,3'b0,dma_addr}`.
- `vram_dout` in 8: VRAM CPU-port read data, registered, one `clk` latency.
- `obj_addr` in 9: object buffer read address from the renderer.
- `obj_dout` out 8: object buffer read data, one `clk` latency.
- `dma_busy` out 1: high from trigger acceptance until the bus is released.

## Operation
- Trigger latch `pend`: set by `dma_trig` on any `clk`. It is cleared when the FSM leaves IDLE. A trigger arriving while busy stays latched and starts a new transfer after DONE.
- FSM states:
  - IDLE: if `pend`, go to REQ and set `dma_busy`=1.
  - REQ: drive `busrq_n`=0 and wait for `busak_n`=0.
  - ADDR: present `dma_addr`.
  - DATA: write `vram_dout` into `buf[dma_addr]`. If `dma_addr`=511, go to DONE. Otherwise increment `dma_addr` and return to ADDR.
  - DONE: set `busrq_n`=1, clear `dma_busy`, set `dma_addr`=0, raise the `fresh` flag, then go to IDLE.
- Each byte takes 2 `cen` steps, so a full transfer is 1024 `cen` steps after acknowledge.
- `busak_n` returning high during ADDR/DATA freezes the FSM and `dma_addr`; no buffer write occurs. The transfer resumes when `busak_n` goes low again.
- `dma_addr` wraps 511→0 only through DONE and never increments past 511.
- Object buffer: dual-port, 512×8. The DMA writes it; `obj_addr` reads it asynchronously to the DMA with 1-`clk` registered output.
- A simultaneous `dma_trig` and DONE re-latches `pend`, so one extra full transfer follows.

## Timing
- Reset values: `busrq_n`=1, `dma_busy`=0, `dma_addr`=0, FSM=IDLE, `pend`=0, `fresh`=0. `obj_dout` is not reset and holds buffer contents.
- Trigger to `busrq_n` low: 2 `cen` steps (IDLE→REQ).
- Acknowledge to first buffer write: 2 `cen` steps.
- Last buffer write to `busrq_n` high: 1 `cen` step.
- Reset mid-transfer releases `busrq_n` immediately (asynchronously). Buffer contents stay partially updated.

## Configuration
- `JTPANG_OBJDMA_DBUF_EN` defined:
  - Two 512-byte banks. The DMA writes the back bank; the renderer reads the front bank.
  - Banks swap on the `vb` rising edge only if `fresh`=1, and `fresh` clears on swap.
  - A transfer still running at the `vb` edge defers the swap to the next `vb` rising edge after DONE.
- Undefined:
  - A single bank is shared by both ports, so the renderer sees bytes as soon as they are written.
  - `vb` and `fresh` are ignored.

## Test plan
- Fill VRAM obj area with `byte[i]=i^8'h5A`, pulse `dma_trig`, acknowledge after 3 `cen` steps → `busrq_n` falls 2 steps after the trigger; `buf[i]=i^8'h5A` for all 512 bytes; `busrq_n` rises 1025 steps after acknowledge.
- Deassert `busak_n` for 10 `cen` steps at `dma_addr`=100 → `dma_addr` holds 100, no writes occur during the gap, and the final buffer contents are identical to the first scenario.
- Pulse `dma_trig` at `dma_addr`=300 → after the first DONE, `busrq_n` falls again and a second full 512-byte transfer completes.
- Assert `rst` at `dma_addr`=200 → `busrq_n`=1 and `dma_busy`=0 the same cycle; bytes 0–199 are updated and 200–511 are unchanged.
- With `JTPANG_OBJDMA_DBUF_EN`: transfer pattern A, raise `vb`, then transfer pattern B with no `vb` edge → `obj_dout` shows A until the next `vb` rise, then B.
- With `JTPANG_OBJDMA_DBUF_EN`: a `vb` rise during a transfer → no swap; the swap occurs at the following `vb` rise.
